// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Streams a program, one byte per accepted beat, into instruction memory.
//   Each load starts at a base address and tracks a byte count and an XOR
//   checksum. The CPU fetch logic is held while the memory image is invalid.
//   A load that runs past DEPTH is aborted and ends in a sticky error.
//
// Parameters
//   DEPTH          number of bytes in instruction memory (legal addresses
//                  are 0..DEPTH-1)
//
// Ports
//   i_clk          single clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_load_start   one-cycle request to begin a load (ignored while loading)
//   i_load_base    first write address, sampled with i_load_start
//   i_in_valid     producer presents a program byte
//   i_in_data      program byte (opcode [7:4], operand [3:0])
//   i_in_last      marks the final byte of the program
//   o_in_ready     loader accepts a byte this cycle (LOAD state only)
//   o_mem_we       memory write strobe, one cycle per written byte
//   o_mem_addr     memory write address (holds when o_mem_we is low)
//   o_mem_wdata    memory write data (holds when o_mem_we is low)
//   o_cpu_hold     holds the fetch/PC logic in LOAD and ERR
//   o_start_pc     latched load base, the PC reset vector after a good load
//   o_byte_count   bytes written in the current/last load
//   o_checksum     XOR of the bytes written in the current/last load
//   o_done         last load completed cleanly (sticky)
//   o_error        last load overflowed DEPTH (sticky)
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int DEPTH = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load_start,
  input  logic [15:0] i_load_base,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  input  logic        i_in_last,
  output logic        o_in_ready,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_cpu_hold,
  output logic [15:0] o_start_pc,
  output logic [15:0] o_byte_count,
  output logic [7:0]  o_checksum,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // 17-bit limit so the pointer compare never truncates DEPTH.
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  state_t      r_state;
  logic [15:0] r_wr_ptr;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic [15:0] r_start_pc;
  logic [15:0] r_byte_count;
  logic [7:0]  r_checksum;
  logic        r_done;
  logic        r_error;

  logic w_in_ready;
  logic w_accept;
  logic w_in_range;

  // Running XOR checksum update for one program byte.
  function automatic logic [7:0] f_xor_accum(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  assign w_in_ready = (r_state == S_LOAD);
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_in_range = ({1'b0, r_wr_ptr} < DEPTH_LIM);

  // Loader FSM together with the registered memory port and load status.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= 16'd0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 16'd0;
      r_mem_wdata  <= 8'd0;
      r_start_pc   <= 16'd0;
      r_byte_count <= 16'd0;
      r_checksum   <= 8'd0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      // The strobe is a single-cycle pulse unless a new beat is written.
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_load_start) begin
            r_state      <= S_LOAD;
            r_wr_ptr     <= i_load_base;
            r_start_pc   <= i_load_base;
            r_byte_count <= 16'd0;
            r_checksum   <= 8'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        S_LOAD: begin
          // i_load_start is deliberately not looked at here.
          if (w_accept) begin
            if (w_in_range) begin
              r_mem_we     <= 1'b1;
              r_mem_addr   <= r_wr_ptr;
              r_mem_wdata  <= i_in_data;
              r_wr_ptr     <= r_wr_ptr + 16'd1;
              r_byte_count <= r_byte_count + 16'd1;
              r_checksum   <= f_xor_accum(r_checksum, i_in_data);
              if (i_in_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_LOAD;
              end
            end else begin
              // Overflow: byte dropped, counters frozen, regardless of last.
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end else begin
            r_state <= S_LOAD;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_cpu_hold   = (r_state == S_LOAD) || (r_state == S_ERR);
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_start_pc   = r_start_pc;
  assign o_byte_count = r_byte_count;
  assign o_checksum   = r_checksum;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule
